// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, FSM states, IR field positions and helpers for mc_datapath_seq
package mc_pkg;

  // Opcode encodings (IR[15:12])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  // Instruction field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 9;
  localparam int RB_HI  = 8;
  localparam int RB_LO  = 6;
  localparam int RC_HI  = 5;
  localparam int RC_LO  = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // Sign-extend a 6-bit immediate; callers take the low bits they need (widths up to 64).
  function automatic logic [63:0] sext6(input logic [5:0] imm);
    return {{58{imm[5]}}, imm};
  endfunction

  // Opcodes the sequencer knows how to execute (HLT included).
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADI, OP_NAND, OP_SW, OP_LW, OP_BEQ, OP_HLT: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational ALU: add with carry-out, or NAND
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  // NAND for the NAND opcode, otherwise an add (ADD/ADI and LW/SW address generation)
  always_comb begin
    {carry, result} = {1'b0, a} + {1'b0, b};
    if (op == OP_NAND) begin
      result = ~(a & b);
      carry  = 1'b0;
    end
    zero = (result == '0);
  end

endmodule

// File: rtl/mc_datapath_seq.sv
// rtl/mc_datapath_seq.sv - multi-cycle datapath with internal sequencer FSM and fetch handshake
module mc_datapath_seq
  import mc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256,
  parameter int PC_W      = 16
) (
  input  logic              clk,
  input  logic              proc_rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic              carry,
  output logic              zero,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t            state, state_n;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr;
  logic              c_q, z_q, ill_q;
  logic              req_i;

  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] ram  [MEM_DEPTH];

  logic [3:0]        op;
  logic [2:0]        ra, rb, rc;
  logic [63:0]       imm64;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_pc;
  logic [AW-1:0]     mem_addr;
  logic              unused_imm;

  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              alu_c, alu_z;

  assign op       = ir[OP_HI:OP_LO];
  assign ra       = ir[RA_HI:RA_LO];
  assign rb       = ir[RB_HI:RB_LO];
  assign rc       = ir[RC_HI:RC_LO];
  assign imm64    = sext6(ir[IMM_HI:IMM_LO]);
  assign imm_d    = imm64[DATA_W-1:0];
  assign imm_pc   = imm64[PC_W-1:0];
  assign unused_imm = ^imm64;
  assign mem_addr = alu_q[AW-1:0];

  // ALU operand select: ADI adds imm to Ra, LW/SW add imm to the Rb base
  always_comb begin
    alu_a = a_q;
    alu_b = b_q;
    if (op == OP_ADI) begin
      alu_b = imm_d;
    end else if (op == OP_LW || op == OP_SW) begin
      alu_a = b_q;
      alu_b = imm_d;
    end
  end

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (op),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge proc_rst_n) begin
    if (!proc_rst_n) state <= ST_FETCH;
    else             state <= state_n;
  end

  // Sequencer next-state, fetch request and retire pulse
  always_comb begin
    state_n = state;
    req_i   = 1'b0;
    retire  = 1'b0;
    case (state)
      ST_FETCH: begin
        req_i = 1'b1;
        if (imem_valid) state_n = ST_DECODE;
      end
      ST_DECODE: begin
        if (op == OP_HLT || !is_legal(op)) state_n = ST_HALT;
        else                               state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (op == OP_BEQ) begin
          retire  = 1'b1;
          state_n = ST_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_n = ST_MEM;
        end else begin
          state_n = ST_WB;
        end
      end
      ST_MEM: begin
        if (op == OP_SW) begin
          retire  = 1'b1;
          state_n = ST_FETCH;
        end else begin
          state_n = ST_WB;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_n = ST_FETCH;
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_FETCH;
    endcase
  end

  // Reset forces FETCH asynchronously, so the request is masked while reset is held
  assign imem_req  = req_i & proc_rst_n;
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign carry     = c_q;
  assign zero      = z_q;
  assign halted    = (state == ST_HALT);
  assign illegal   = ill_q;
  assign dbg_data  = regs[dbg_addr];

  // Architectural state: PC, IR, operand latches, ALU result, flags, register file
  always_ff @(posedge clk or negedge proc_rst_n) begin
    if (!proc_rst_n) begin
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      ill_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_valid) ir <= imem_rdata;
        end
        ST_DECODE: begin
          a_q <= regs[ra];
          b_q <= regs[rb];
          if (!is_legal(op)) ill_q <= 1'b1;
        end
        ST_EXEC: begin
          alu_q <= alu_res;
          if (op == OP_ADD || op == OP_ADI) begin
            c_q <= alu_c;
            z_q <= alu_z;
          end else if (op == OP_NAND) begin
            z_q <= alu_z;
          end else if (op == OP_BEQ) begin
            pc <= (a_q == b_q) ? pc + imm_pc : pc + PC_W'(1);
          end
        end
        ST_MEM: begin
          // LW's zero flag can only be known once the word is read
          if (op == OP_LW) z_q <= (ram[mem_addr] == '0);
          if (op == OP_SW) pc <= pc + PC_W'(1);
        end
        ST_WB: begin
          pc <= pc + PC_W'(1);
          case (op)
            OP_ADD, OP_NAND: regs[rc] <= alu_q;
            OP_ADI:          regs[rb] <= alu_q;
            OP_LW:           regs[ra] <= mdr;
            default:         ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Data RAM and MDR; contents survive reset, and reset aborts a pending SW
  always_ff @(posedge clk) begin
    if (state == ST_MEM) begin
      mdr <= ram[mem_addr];
      if (op == OP_SW && proc_rst_n) ram[mem_addr] <= a_q;
    end
  end

endmodule

// File: tb/tb_mc_datapath_seq.sv
// tb/tb_mc_datapath_seq.sv - self-checking bench for mc_datapath_seq
module tb_mc_datapath_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        proc_rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] pc_out;
  logic        carry, zero, retire, halted, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic        rst4_n;
  logic        req4;
  logic [3:0]  addr4;
  logic [15:0] rdata4;
  logic        valid4;
  logic [3:0]  pc4;
  logic        carry4, zero4, retire4, halted4, illegal4;
  logic [2:0]  dbg4_addr;
  logic [15:0] dbg4_data;

  mc_datapath_seq #(.DATA_W(16), .MEM_DEPTH(256), .PC_W(16)) dut (
    .clk(clk), .proc_rst_n(proc_rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc_out(pc_out), .carry(carry),
    .zero(zero), .retire(retire), .halted(halted), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  mc_datapath_seq #(.DATA_W(16), .MEM_DEPTH(256), .PC_W(4)) dut4 (
    .clk(clk), .proc_rst_n(rst4_n), .imem_req(req4), .imem_addr(addr4),
    .imem_rdata(rdata4), .imem_valid(valid4), .pc_out(pc4), .carry(carry4),
    .zero(zero4), .retire(retire4), .halted(halted4), .illegal(illegal4),
    .dbg_addr(dbg4_addr), .dbg_data(dbg4_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered in a FETCH cycle (just after a negedge); returns latency in cycles counted
  // from the first fetch cycle to the retire (or halt) cycle, and dbg_data seen then.
  task automatic run_instr(input logic [15:0] instr, input int waits, input logic [15:0] exp_addr,
                           output int lat, output logic [15:0] dbg_at_end);
    logic done;
    lat = 0;
    dbg_at_end = '0;
    for (int w = 0; w < waits; w++) begin
      imem_valid = 1'b0;
      lat++;
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, exp_addr);
      @(negedge clk);
    end
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, exp_addr);
    imem_rdata = instr;
    imem_valid = 1'b1;
    lat++;
    @(posedge clk);
    #1 imem_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (retire || halted) begin
        done = 1'b1;
        dbg_at_end = dbg_data;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout instr=%0h no retire/halt within 20 cycles", instr);
    end else if (retire) begin
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    int          waits;
    int          lat;
    logic [15:0] pc;
    logic [2:0]  dbg;
    logic [15:0] old_v;
    logic [15:0] new_v;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl [10];
  logic [15:0] prog4 [2];
  logic [3:0]  pc4_exp [2];

  initial begin
    int          lat;
    logic [15:0] dv;
    logic [15:0] fetch_pc;
    logic        done;

    tbl[0] = '{16'h1045, 0, 4, 16'd1,  3'd1, 16'h0000, 16'h0005, 1'b0, 1'b0};
    tbl[1] = '{16'h10BF, 0, 4, 16'd2,  3'd2, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    tbl[2] = '{16'h0498, 0, 4, 16'd3,  3'd3, 16'h0000, 16'hFFFE, 1'b1, 1'b0};
    tbl[3] = '{16'h24A8, 0, 4, 16'd4,  3'd5, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h9203, 0, 4, 16'd5,  3'd1, 16'h0005, 16'h0005, 1'b1, 1'b1};
    tbl[5] = '{16'hA803, 0, 5, 16'd6,  3'd4, 16'h0000, 16'h0005, 1'b1, 1'b0};
    tbl[6] = '{16'hC004, 0, 3, 16'd10, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'hC204, 0, 3, 16'd11, 3'd1, 16'h0005, 16'h0005, 1'b1, 1'b0};
    tbl[8] = '{16'h0330, 3, 7, 16'd12, 3'd6, 16'h0000, 16'h000A, 1'b0, 1'b0};
    tbl[9] = '{16'h17C2, 0, 4, 16'd13, 3'd7, 16'h0000, 16'h0000, 1'b1, 1'b1};

    proc_rst_n = 1'b0;
    imem_rdata = '0;
    imem_valid = 1'b0;
    dbg_addr   = 3'd0;
    rst4_n     = 1'b0;
    rdata4     = '0;
    valid4     = 1'b0;
    dbg4_addr  = 3'd0;

    #1;
    check("rst_req", imem_req, 0);
    check("rst_pc", pc_out, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    repeat (3) @(negedge clk);
    check("rst_req_held", imem_req, 0);
    proc_rst_n = 1'b1;
    #1 check("first_req", imem_req, 1);

    fetch_pc = 16'd0;
    for (int i = 0; i < 10; i++) begin
      dbg_addr = tbl[i].dbg;
      run_instr(tbl[i].instr, tbl[i].waits, fetch_pc, lat, dv);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_pc", i), pc_out, tbl[i].pc);
      check($sformatf("v%0d_dbg_old", i), dv, tbl[i].old_v);
      check($sformatf("v%0d_dbg_new", i), dbg_data, tbl[i].new_v);
      check($sformatf("v%0d_carry", i), carry, tbl[i].c);
      check($sformatf("v%0d_zero", i), zero, tbl[i].z);
      fetch_pc = tbl[i].pc;
    end

    // Reset in the middle of a fetch wait
    dbg_addr = 3'd6;
    imem_valid = 1'b0;
    repeat (2) begin
      check("midwait_req", imem_req, 1);
      check("midwait_addr", imem_addr, 16'd13);
      @(negedge clk);
    end
    proc_rst_n = 1'b0;
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_pc", pc_out, 0);
    check("midrst_reg", dbg_data, 0);
    check("midrst_carry", carry, 0);
    check("midrst_zero", zero, 0);
    @(negedge clk);
    check("midrst_req_held", imem_req, 0);
    proc_rst_n = 1'b1;
    #1;
    check("rerelease_req", imem_req, 1);
    check("rerelease_addr", imem_addr, 0);

    // Illegal opcode at PC=1 halts with illegal set; valid is ignored in HALT
    run_instr(16'h1045, 0, 16'd0, lat, dv);
    check("pre_ill_pc", pc_out, 1);
    run_instr(16'h3000, 0, 16'd1, lat, dv);
    check("ill_latency", lat, 3);
    check("ill_halted", halted, 1);
    check("ill_flag", illegal, 1);
    imem_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("ill_no_req", imem_req, 0);
      check("ill_pc_frozen", pc_out, 1);
      check("ill_no_retire", retire, 0);
      check("ill_still_halted", halted, 1);
    end
    imem_valid = 1'b0;

    // HLT halts without illegal
    proc_rst_n = 1'b0;
    @(negedge clk);
    proc_rst_n = 1'b1;
    #1;
    run_instr(16'hF000, 0, 16'd0, lat, dv);
    check("hlt_latency", lat, 3);
    check("hlt_halted", halted, 1);
    check("hlt_illegal", illegal, 0);
    @(negedge clk);
    check("hlt_no_req", imem_req, 0);

    // PC wrap on the PC_W=4 instance: BEQ R0,R0,-1 at 0 -> 15, then ADD at 15 -> 0
    prog4[0] = 16'hC03F;  pc4_exp[0] = 4'd15;
    prog4[1] = 16'h0000;  pc4_exp[1] = 4'd0;
    rst4_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("w%0d_req", k), req4, 1);
      rdata4 = prog4[k];
      valid4 = 1'b1;
      @(posedge clk);
      #1 valid4 = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (retire4) done = 1'b1;
      end
      check($sformatf("w%0d_retired", k), done, 1);
      @(negedge clk);
      check($sformatf("w%0d_pc", k), pc4, pc4_exp[k]);
      check($sformatf("w%0d_addr", k), addr4, pc4_exp[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_datapath_seq.md
Name: mc_datapath_seq

Overview:
- Parametrised successor to the 16-bit multi-cycle datapath: owns PC, IR, 8-entry register file, ALU, flags and data RAM, plus an internal sequencer FSM that replaces the external per-cycle control strobes.
- Fetches instructions over a request/valid handshake and sits between the instruction-memory wrapper and the top-level processor shell.

Parameters:
- DATA_W, 16, register/ALU/data-RAM word width; must be >= 16.
- MEM_DEPTH, 256, data RAM words (power of two); address = low log2(MEM_DEPTH) bits of the effective address.
- PC_W, 16, PC width; PC increments wrap modulo 2^PC_W.

Ports:
- clk  in  1  single clock, rising edge.
- proc_rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held high until imem_valid.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_rdata  in  16  instruction word, sampled when imem_req && imem_valid.
- imem_valid  in  1  fetch data valid.
- pc_out  out  PC_W  current PC.
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high in HALT state.
- illegal  out  1  high when halted by an undefined opcode.
- dbg_addr  in  3  debug register-read index.
- dbg_data  out  DATA_W  combinational read of register dbg_addr.

Behaviour:
- Fields: op=IR[15:12], Ra=IR[11:9], Rb=IR[8:6], Rc=IR[5:3], imm6=IR[5:0], sign-extended to DATA_W/PC_W.
- Opcodes:
  - 0000 ADD: Rc=Ra+Rb; sets C and Z.
  - 0010 NAND: Rc=~(Ra&Rb); sets Z, C unchanged.
  - 0001 ADI: Rb=Ra+sext(imm6); sets C and Z.
  - 1010 LW: Ra=mem[Rb+sext(imm6)]; sets Z.
  - 1001 SW: mem[Rb+sext(imm6)]=Ra.
  - 1100 BEQ: PC=PC+sext(imm6) if Ra==Rb, else PC+1.
  - 1111 HLT.
  - Any other opcode is illegal.
- C = carry-out of the DATA_W-bit add. Z = (result == 0).
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1; when imem_valid, latch IR, go to DECODE. Wait states are unbounded.
  - DECODE: latch A=reg[Ra] and B=reg[Rb]. HLT goes to HALT; illegal goes to HALT and sets illegal=1; otherwise go to EXEC.
  - EXEC: ALUOUT and flags registered. BEQ updates PC, pulses retire, returns to FETCH. LW/SW go to MEM; all others go to WB.
  - MEM: LW latches MDR=mem[addr], then WB. SW writes the RAM, PC+=1, retire, then FETCH.
  - WB: register write, PC+=1, retire, then FETCH.
- Latency with zero-wait fetch: ADD/NAND/ADI 4 cycles, LW 5, SW 4, BEQ 3. Each fetch wait cycle adds one.
- Flags update only in EXEC of flag-setting ops.
- Register write and debug read in the same cycle: dbg_data shows the old value.
- imem_valid outside FETCH is ignored.
- Register-file write to the register being read in DECODE of the next instruction cannot occur (sequential), so no bypass is needed.
- HALT is exited only by reset; PC frozen, imem_req=0.
- Reset (async, any state, including mid-fetch or mid-MEM):
  - State=FETCH, PC=0, all registers=0, C=Z=0, IR=0.
  - imem_req=0 while reset is asserted; the first request is in the first cycle after release.
  - retire=0, halted=0, illegal=0.
  - An SW in progress does not write. RAM contents are not reset.

Decomposition:
- Shared package mc_pkg:
  - Opcode constants.
  - FSM state enum.
  - IR field bit positions.
  - sext helper function.
- One sub-module: mc_alu, combinational with inputs A, B, op and outputs result, carry, zero, parametrised by DATA_W.
- Register file and RAM are inline arrays.

Test Plan:
- Reset then zero-wait fetch of ADI R1=R0+5 (0x1045) -> imem_req high in the first cycle after release; retire at cycle 4; dbg R1=5; pc_out=1; Z=0.
- ADI R2=R0+(-1) (0x1080 | 0x3F), then ADD R3=R2+R2 -> R3=0xFFFE; carry=1. Then NAND of R2,R2 -> 0 with zero=1 and carry still 1.
- SW R1 to [R0+3], then LW R4 from [R0+3] -> R4=5; LW retires 5 cycles after its fetch; SW retire 4 cycles after its fetch.
- BEQ R0,R0,+4 at PC=6 -> pc_out=10 after 3 cycles. BEQ R1,R0 with R1=5 -> pc_out=PC+1.
- Fetch with 3 imem_valid wait cycles -> imem_req held for 4 cycles and imem_addr stable; ADD retires at cycle 7. Also: proc_rst_n low mid-wait -> imem_req drops immediately and PC=0.
- Opcode 0x3xxx -> halted=1 and illegal=1 after DECODE, no further requests. Opcode 0xF000 -> halted=1, illegal=0. PC wrap with PC_W=4: PC=15 plus ADD -> pc_out=0.
